// File: rtl/reg_wb_arb.sv
// Round-robin write-back arbiter for three requesters with a pending-register scoreboard.
// Provides a registered register-file write port, hazard check ports and a saturating contention counter.
module reg_wb_arb #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    output logic [2:0]        req_ready,
    input  logic [3*AW-1:0]   req_addr,
    input  logic [3*DW-1:0]   req_data,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [AW-1:0]     chk_a0,
    input  logic [AW-1:0]     chk_a1,
    output logic              chk_pend0,
    output logic              chk_pend1,
    output logic              we,
    output logic [AW-1:0]     wa,
    output logic [DW-1:0]     wd,
    output logic [2**AW-1:0]  pend,
    output logic [15:0]       cnt_conf
);

    typedef enum logic [1:0] {
        PTR0 = 2'd0,
        PTR1 = 2'd1,
        PTR2 = 2'd2
    } ptr_e;

    function automatic ptr_e nxt(input ptr_e p);
        case (p)
            PTR0:    return PTR1;
            PTR1:    return PTR2;
            default: return PTR0;
        endcase
    endfunction

    ptr_e             ptr_q, ptr_d;
    ptr_e             order [3];
    ptr_e             gnt_idx;
    logic [2:0]       gnt;
    logic             found;
    logic             transfer;
    logic             contend;
    logic [AW-1:0]    gnt_addr;
    logic [DW-1:0]    gnt_data;
    logic             we_q, we_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [DW-1:0]    wd_q, wd_d;
    logic [2**AW-1:0] pend_q, pend_d;
    logic [15:0]      cnt_q, cnt_d;

    always_comb begin
        order[0] = ptr_q;
        order[1] = nxt(order[0]);
        order[2] = nxt(order[1]);
        gnt      = '0;
        gnt_idx  = PTR0;
        found    = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!found && req_valid[order[k]]) begin
                gnt[order[k]] = 1'b1;
                gnt_idx       = order[k];
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (int'(gnt_idx) == int'(k)) begin
                gnt_addr = req_addr[k*AW +: AW];
                gnt_data = req_data[k*DW +: DW];
            end
        end
    end

    // Grants are masked while reset is held so nothing can be accepted then.
    assign req_ready = rst ? gnt : '0;
    assign transfer  = |req_ready;
    assign contend   = (req_valid[0] & req_valid[1]) |
                       (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

    always_comb begin
        ptr_d = ptr_q;
        we_d  = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (transfer) begin
            ptr_d = nxt(gnt_idx);
            we_d  = (gnt_addr != '0);
            wa_d  = gnt_addr;
            wd_d  = gnt_data;
        end
        // Reservation is applied after the clear so a same-edge set wins.
        pend_d = pend_q;
        if (we_q) pend_d[wa_q] = 1'b0;
        if (rsv_valid) pend_d[rsv_addr] = 1'b1;
        pend_d[0] = 1'b0;
        cnt_d = cnt_q;
        if (contend && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q  <= PTR0;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Hazard flags ignore a register whose write is being presented this cycle.
    assign chk_pend0 = pend_q[chk_a0] & ~(we_q && (wa_q == chk_a0));
    assign chk_pend1 = pend_q[chk_a1] & ~(we_q && (wa_q == chk_a1));

    assign we       = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign pend     = pend_q;
    assign cnt_conf = cnt_q;

endmodule

// File: tb/tb_reg_wb_arb.sv
// Scoreboard bench for reg_wb_arb: stimulus queues expected grants and writes, a monitor checks them.
module tb_reg_wb_arb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_valid;
    logic [2:0]        req_ready;
    logic [3*AW-1:0]   req_addr;
    logic [3*DW-1:0]   req_data;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic [AW-1:0]     chk_a0, chk_a1;
    logic              chk_pend0, chk_pend1;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [2**AW-1:0]  pend;
    logic [15:0]       cnt_conf;

    always #5 clk = ~clk;

    reg_wb_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_a0(chk_a0), .chk_a1(chk_a1),
        .chk_pend0(chk_pend0), .chk_pend1(chk_pend1),
        .we(we), .wa(wa), .wd(wd),
        .pend(pend), .cnt_conf(cnt_conf)
    );

    int total = 0;
    int bad   = 0;

    logic [2:0]       exp_rdy_q [$];
    logic [AW+DW-1:0] exp_wr_q  [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every presented grant and write is matched against the queues.
    always @(negedge clk) begin
        if (req_ready !== 3'b000) begin
            if (exp_rdy_q.size() == 0) chk("unexpected_ready", 64'(req_ready), 64'd0);
            else                       chk("grant", 64'(req_ready), 64'(exp_rdy_q.pop_front()));
        end
        if (we === 1'b1) begin
            if (exp_wr_q.size() == 0) chk("unexpected_write", 64'(we), 64'd0);
            else                      chk("write_wa_wd", 64'({wa, wd}), 64'(exp_wr_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic expect_gnt(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_rdy_q.push_back(3'b001 << i);
        if (a != '0) exp_wr_q.push_back({a, d});
    endtask

    task automatic idle();
        req_valid = 3'b000;
    endtask

    initial begin
        rst       = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_a0    = '0;
        chk_a1    = '0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222);
        #3;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_wa_wd", 64'({wa, wd}), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        tick();
        tick();
        chk("rst_cnt_held", 64'(cnt_conf), 64'd0);

        // Round robin from reset: grants 0,1,2,0.
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            case (c % 3)
                0:       expect_gnt(0, 5'd1, 32'hA0A0_0000);
                1:       expect_gnt(1, 5'd2, 32'hA1A1_1111);
                default: expect_gnt(2, 5'd3, 32'hA2A2_2222);
            endcase
            tick();
        end
        idle();
        chk("rr_cnt_conf", 64'(cnt_conf), 64'd4);
        tick();

        // Single requester 0 (pointer now at 1, search wraps to 0).
        drive(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'd0, 32'd0);
        expect_gnt(0, 5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        chk("single_we", 64'(we), 64'd1);
        chk("single_cnt", 64'(cnt_conf), 64'd4);
        tick();

        // Address zero from requester 1: accepted, no write, pend untouched.
        drive(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h1234_5678, 32'd0);
        expect_gnt(1, 5'd0, 32'h1234_5678);
        tick();
        idle();
        chk("addr0_we", 64'(we), 64'd0);
        chk("addr0_pend", 64'(pend), 64'd0);
        tick();

        // Reserve r7, then write it from requester 2.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk_a0 = 5'd7;
        chk_a1 = 5'd3;
        #1;
        chk("rsv_pend", 64'(pend), 64'h80);
        chk("rsv_chk_pend0", 64'(chk_pend0), 64'd1);
        chk("rsv_chk_pend1", 64'(chk_pend1), 64'd0);
        drive(3'b100, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h0000_0077);
        expect_gnt(2, 5'd7, 32'h0000_0077);
        #1;
        chk("req_chk_pend0", 64'(chk_pend0), 64'd1);
        tick();
        idle();
        chk("bypass_chk_pend0", 64'(chk_pend0), 64'd0);
        chk("bypass_pend_still", 64'(pend), 64'h80);
        tick();
        chk("clear_pend", 64'(pend), 64'd0);
        chk("clear_chk_pend0", 64'(chk_pend0), 64'd0);

        // Set and clear of r7 on the same edge: set wins.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        drive(3'b001, 5'd7, 5'd0, 5'd0, 32'h0000_1234, 32'd0, 32'd0);
        expect_gnt(0, 5'd7, 32'h0000_1234);
        tick();
        idle();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk("same_edge_pend", 64'(pend), 64'h80);

        // Reset mid-write with pend=0x80.
        drive(3'b010, 5'd0, 5'd9, 5'd0, 32'd0, 32'h0000_0099, 32'd0);
        expect_gnt(1, 5'd9, 32'h0000_0099);
        tick();
        idle();
        @(negedge clk);
        #2;
        chk("pre_rst_we", 64'(we), 64'd1);
        chk("pre_rst_pend", 64'(pend), 64'h80);
        drive(3'b111, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        rst = 1'b0;
        #1;
        chk("async_rst_we", 64'(we), 64'd0);
        chk("async_rst_pend", 64'(pend), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        chk("async_rst_cnt", 64'(cnt_conf), 64'd0);
        tick();

        // Release with contention held: first grant to 0, then saturation.
        rst = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            expect_gnt(n % 3, 5'd0, 32'd0);
            tick();
        end
        idle();
        chk("sat_cnt_conf", 64'(cnt_conf), 64'hFFFF);
        chk("sat_we", 64'(we), 64'd0);
        tick();
        tick();
        chk("rdy_queue_empty", 64'(exp_rdy_q.size()), 64'd0);
        chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst (rst asserted = 0).
REQ-002 Parameter AW SHALL default to 5 and set the register address width.
REQ-003 Parameter DW SHALL default to 32 and set the register data width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async reset, active low.
REQ-006 req_valid  input  3  write request per requester (0=ALU, 1=load, 2=debug).
REQ-007 req_ready  output  3  grant/accept per requester.
REQ-008 req_addr  input  3*AW  requester i address at bits [AW*i+AW-1 : AW*i].
REQ-009 req_data  input  3*DW  requester i data at bits [DW*i+DW-1 : DW*i].
REQ-010 rsv_valid  input  1  reserve a destination register, marking it pending.
REQ-011 rsv_addr  input  AW  register to reserve.
REQ-012 chk_a0, chk_a1  input  AW each  source addresses to hazard-check.
REQ-013 chk_pend0, chk_pend1  output  1 each  hazard flag for chk_a0 and chk_a1.
REQ-014 we, wa, wd  output  1, AW, DW  registered write port to the register file.
REQ-015 pend  output  2**AW  scoreboard vector.
REQ-016 cnt_conf  output  16  saturating count of contention cycles.

Function
REQ-017 Arbitration SHALL be round-robin from pointer ptr (0..2), searching ptr, ptr+1, ptr+2 mod 3.
REQ-018 req_ready SHALL be combinational and one-hot or zero: only the first valid requester in search order gets ready.
REQ-019 A transfer SHALL occur on an edge where req_valid[i]=1 and req_ready[i]=1.
REQ-020 Pointer update: after a grant to i, ptr SHALL become (i+1) mod 3; with no grant, ptr SHALL be unchanged.
REQ-021 The output stage SHALL be updated on the transfer edge:
- we=1 if the granted address is not 0, otherwise we=0.
- wa and wd SHALL be loaded with the granted address and data.
- Latency from accept to we high SHALL be one cycle.
REQ-022 With no transfer, we SHALL be 0 the next cycle, and wa/wd SHALL hold their values.
REQ-023 A write to address 0 SHALL be accepted (ready asserted) but suppressed (we=0) and SHALL NOT touch pend.
REQ-024 Scoreboard set: pend[r] SHALL be set on the edge where rsv_valid=1 and rsv_addr=r, for r!=0.
REQ-025 Scoreboard clear: pend[r] SHALL be cleared on the edge where we=1 and wa=r.
REQ-026 If set and clear hit the same r on one edge, the set SHALL win.
REQ-027 pend[0] SHALL always be 0.
REQ-028 chk_pendN SHALL equal pend[chk_aN] AND NOT (we=1 and wa=chk_aN), i.e. it is combinational and bypasses the write in progress.
REQ-029 cnt_conf SHALL increment on every edge where two or more req_valid bits are 1, and SHALL saturate at 0xFFFF.
REQ-030 Requesters SHALL hold addr/data stable while valid is high and not yet accepted; the block SHALL NOT latch unaccepted requests.

Reset
REQ-031 While rst=0, asynchronously:
- ptr=0, we=0, wa=0, wd=0, pend=0, cnt_conf=0.
- req_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL drop the registered write (we=0 immediately) and clear all pending bits.
REQ-033 The first grant after reset release SHALL follow search order 0,1,2.

Verification
REQ-034 Single requester: req_valid=001, addr=5, data=0xDEADBEEF -> ready=001 that cycle; next cycle we=1, wa=5, wd=0xDEADBEEF.
REQ-035 Round-robin: all three valid for 4 cycles -> grants 0,1,2,0, and cnt_conf=4.
REQ-036 Address zero: requester 1 writes addr 0 -> ready=010; next cycle we=0; pend unchanged.
REQ-037 Scoreboard, set then clear:
- Reserve r7, then request a write to 7 -> chk_a0=7 gives chk_pend0=1 until the cycle we=1/wa=7, where it reads 0.
- pend[7]=0 after that edge.
REQ-038 Scoreboard, simultaneous events: reserve r7 on the same edge that clears r7 -> pend[7]=1 after the edge.
REQ-039 Reset and saturation:
- Assert rst=0 while we=1 and pend=0x80 -> we=0 and pend=0 immediately; the first grant after release goes to requester 0.
- Hold contention for 70000 cycles -> cnt_conf=0xFFFF.
